// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: sequential fetch from a combinational instruction
// memory into a 2-entry {pc, instr} buffer, with redirect flush and a sticky fault.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IM_SIZE  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] retire_cnt
);

  // Last byte address at which a whole word still fits inside the memory.
  localparam logic [31:0] IM_LAST = 32'(IM_SIZE) - 32'd4;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, instr0_q, instr0_d;
  logic [31:0] pc1_q, pc1_d, instr1_q, instr1_d;
  logic        fault_q, fault_d;
  logic [31:0] retire_q, retire_d;

  logic fetch_ok;
  logic pop;
  logic enq;

  // Handshake: the head entry transfers on a cycle where out_valid && out_ready
  // at the rising edge; out_valid never depends on out_ready, and the head entry
  // is held stable while out_valid && !out_ready unless a redirect flushes it.
  assign pop      = out_valid && out_ready;
  assign fetch_ok = !fault_q && (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q <= IM_LAST);
  assign enq      = !redirect && fetch_ok && ((count_q < 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= 2'd0;
      pc0_q      <= 32'd0;
      instr0_q   <= 32'd0;
      pc1_q      <= 32'd0;
      instr1_q   <= 32'd0;
      fault_q    <= 1'b0;
      retire_q   <= 32'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      instr0_q   <= instr0_d;
      pc1_q      <= pc1_d;
      instr1_q   <= instr1_d;
      fault_q    <= fault_d;
      retire_q   <= retire_d;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    instr0_d   = instr0_q;
    pc1_d      = pc1_q;
    instr1_d   = instr1_q;
    fault_d    = fault_q;
    retire_d   = pop ? retire_q + 32'd1 : retire_q;

    if (redirect) begin
      // Decode still consumed the head if it popped, so retire_d is kept above.
      count_d    = 2'd0;
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
    end else begin
      if (!fetch_ok && !fault_q) begin
        fault_d = 1'b1;
      end
      if (enq) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      case (count_q)
        2'd0: begin
          if (enq) begin
            pc0_d    = fetch_pc_q;
            instr0_d = im_instr;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (pop && enq) begin
            pc0_d    = fetch_pc_q;
            instr0_d = im_instr;
          end else if (pop) begin
            count_d = 2'd0;
          end else if (enq) begin
            pc1_d    = fetch_pc_q;
            instr1_d = im_instr;
            count_d  = 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            pc0_d    = pc1_q;
            instr0_d = instr1_q;
            if (enq) begin
              pc1_d    = fetch_pc_q;
              instr1_d = im_instr;
            end else begin
              count_d = 2'd1;
            end
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_comb begin
    im_addr    = fetch_pc_q;
    out_valid  = (count_q != 2'd0);
    out_instr  = instr0_q;
    out_pc     = pc0_q;
    fault      = fault_q;
    retire_cnt = retire_q;
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a combinational memory model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  instr_fetch_ctrl #(.RESET_PC(32'd0), .IM_SIZE(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .im_addr    (im_addr),
    .im_instr   (im_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  always_comb im_instr = mem_word(im_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    out_ready   = ready;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
    checks++; if (im_addr !== 32'd0) begin failures++; $display("FAIL reset_im_addr got=%h exp=0", im_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc); end
      checks++; if (out_instr !== mem_word(exp_pc)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, mem_word(exp_pc)); end
      step();
    end
    checks++; if (retire_cnt !== 32'd4) begin failures++; $display("FAIL stream_retire got=%0d exp=4", retire_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (5) step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL bp_hold_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== mem_word(32'd0)) begin failures++; $display("FAIL bp_hold_instr got=%h exp=%h", out_instr, mem_word(32'd0)); end
    checks++; if (im_addr !== 32'd8) begin failures++; $display("FAIL bp_im_addr got=%h exp=8", im_addr); end
    checks++; if (retire_cnt !== 32'd0) begin failures++; $display("FAIL bp_retire0 got=%0d exp=0", retire_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'd4) begin failures++; $display("FAIL bp_drain1 got=%h exp=4", out_pc); end
    step();
    checks++; if (out_pc !== 32'd8) begin failures++; $display("FAIL bp_drain2 got=%h exp=8", out_pc); end
    checks++; if (retire_cnt !== 32'd2) begin failures++; $display("FAIL bp_retire2 got=%0d exp=2", retire_cnt); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step();
    step();
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++; if (retire_cnt !== 32'd1) begin failures++; $display("FAIL redir_retire got=%0d exp=1", retire_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", out_valid); end
    checks++; if (im_addr !== 32'h40) begin failures++; $display("FAIL redir_im_addr got=%h exp=40", im_addr); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL redir_valid got=%b exp=1", out_valid); end
    checks++; if (out_pc !== 32'h40) begin failures++; $display("FAIL redir_pc got=%h exp=40", out_pc); end
    checks++; if (out_instr !== mem_word(32'h40)) begin failures++; $display("FAIL redir_instr got=%h exp=%h", out_instr, mem_word(32'h40)); end
    step();
    checks++; if (out_pc !== 32'h44) begin failures++; $display("FAIL redir_next_pc got=%h exp=44", out_pc); end
  endtask

  task automatic test_im_end();
    do_reset(1'b1);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'd120;
    step();
    redirect = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL end_bubble got=%b exp=0", out_valid); end
    step();
    checks++; if (out_pc !== 32'd120) begin failures++; $display("FAIL end_pc120 got=%0d exp=120", out_pc); end
    step();
    checks++; if (out_pc !== 32'd124) begin failures++; $display("FAIL end_pc124 got=%0d exp=124", out_pc); end
    checks++; if (im_addr !== 32'd128) begin failures++; $display("FAIL end_im_addr got=%0d exp=128", im_addr); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL end_fault_early got=%b exp=0", fault); end
    step();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL end_fault got=%b exp=1", fault); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL end_no128 got=%b exp=0", out_valid); end
    checks++; if (im_addr !== 32'd128) begin failures++; $display("FAIL end_pc_hold got=%0d exp=128", im_addr); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL end_still_empty got=%b exp=0", out_valid); end
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL end_sticky got=%b exp=1", fault); end
    checks++; if (retire_cnt !== 32'd3) begin failures++; $display("FAIL end_retire got=%0d exp=3", retire_cnt); end
  endtask

  task automatic test_fault_drain();
    do_reset(1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'd120;
    step();
    redirect = 1'b0;
    step();
    step();
    step();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL drain_fault got=%b exp=1", fault); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid got=%b exp=1", out_valid); end
    checks++; if (out_pc !== 32'd120) begin failures++; $display("FAIL drain_head got=%0d exp=120", out_pc); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'd124) begin failures++; $display("FAIL drain_second got=%0d exp=124", out_pc); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_second_valid got=%b exp=1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    checks++; if (retire_cnt !== 32'd2) begin failures++; $display("FAIL drain_retire got=%0d exp=2", retire_cnt); end
  endtask

  task automatic test_misaligned();
    do_reset(1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h6;
    step();
    redirect = 1'b0;
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_fault_early got=%b exp=0", fault); end
    checks++; if (im_addr !== 32'h6) begin failures++; $display("FAIL mis_im_addr got=%h exp=6", im_addr); end
    step();
    checks++; if (fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", fault); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mis_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mis_valid_persist got=%b exp=0", out_valid); end
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL mis_fault_clear got=%b exp=0", fault); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mis_recover_valid got=%b exp=1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL mis_recover_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== mem_word(32'h0)) begin failures++; $display("FAIL mis_recover_instr got=%h exp=%h", out_instr, mem_word(32'h0)); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'd120;
    step();
    redirect = 1'b0;
    repeat (3) step();
    checks++; if (out_valid !== 1'b1 || fault !== 1'b1) begin failures++; $display("FAIL arst_pre got valid=%b fault=%b exp 1 1", out_valid, fault); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL arst_fault got=%b exp=0", fault); end
    checks++; if (im_addr !== 32'd0) begin failures++; $display("FAIL arst_im_addr got=%h exp=0", im_addr); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL arst_out_pc got=%h exp=0", out_pc); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_hold got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_restart_valid got=%b exp=1", out_valid); end
    checks++; if (out_pc !== 32'd0) begin failures++; $display("FAIL arst_restart_pc got=%h exp=0", out_pc); end
    checks++; if (im_addr !== 32'd4) begin failures++; $display("FAIL arst_restart_im got=%h exp=4", im_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_im_end();
    test_fault_drain();
    test_misaligned();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning first fetch address after reset.
REQ-002 SHALL have parameter IM_SIZE, default 128, meaning instruction memory size in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port im_addr, output, 32, the byte address driven to the instruction memory InstrAddr.
REQ-006 SHALL have port im_instr, input, 32, the big-endian word returned combinationally, same cycle, from im_addr.
REQ-007 SHALL have port out_valid, output, 1, meaning the head buffer entry is presented to decode.
REQ-008 SHALL have port out_ready, input, 1, meaning decode accepts the head entry this cycle.
REQ-009 SHALL have port out_instr, output, 32, the head entry instruction.
REQ-010 SHALL have port out_pc, output, 32, the head entry address.
REQ-011 SHALL have port redirect, input, 1, a branch or jump flush request.
REQ-012 SHALL have port redirect_pc, input, 32, the new fetch address, sampled when redirect=1.
REQ-013 SHALL have port fault, output, 1, a sticky fetch fault flag.
REQ-014 SHALL have port retire_cnt, output, 32, the count of accepted (popped) entries.

Function
REQ-015 SHALL hold fetch_pc register; im_addr = fetch_pc combinationally at all times.
REQ-016 SHALL contain a 2-entry FIFO of {pc, instr}; out_valid = (count != 0); out_instr/out_pc = head entry.
REQ-017 Pop SHALL occur when out_valid && out_ready; retire_cnt increments by 1 per pop, wrapping modulo 2^32.
REQ-018 Enqueue SHALL occur when fetch_ok && (count < 2 || pop), capturing {fetch_pc, im_instr}; fetch_pc <= fetch_pc + 4 on enqueue.
REQ-019 fetch_ok SHALL equal !fault && fetch_pc[1:0] == 0 && fetch_pc <= IM_SIZE-4 (unsigned compare, full 32 bits).
REQ-020 When !fetch_ok && !fault && !redirect, fault SHALL set next cycle; fetch_pc holds; no enqueue.
REQ-021 fault SHALL be sticky until redirect or reset; already-buffered entries keep draining normally.
REQ-022 Simultaneous pop and enqueue at count=2 SHALL keep count=2 with order preserved; at count=1 it SHALL keep count=1.
REQ-023 On count=2 without pop, fetch SHALL stall: fetch_pc and buffer unchanged.
REQ-024 redirect SHALL take priority over pop and enqueue: buffer flushed (count=0), fetch_pc <= redirect_pc, fault cleared, no enqueue that cycle.
REQ-025 A pop coinciding with redirect SHALL still increment retire_cnt (decode consumed the head entry).
REQ-026 After redirect, out_valid SHALL be 0 for exactly one cycle, then present the redirect-target entry if fetch_ok.
REQ-027 out_instr/out_pc SHALL stay stable while out_valid && !out_ready (no redirect).
REQ-028 fetch_pc + 4 SHALL wrap modulo 2^32; any resulting out-of-range address is caught by REQ-019.

Reset
REQ-029 While rst_n=0: fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, fault=0, retire_cnt=0, applied asynchronously.
REQ-030 Reset assertion mid-operation SHALL discard buffer and fault immediately; first enqueue occurs on the first rising edge after release.

Verification
REQ-031 Reset release, out_ready=1, memory holds words W0..W3 at 0,4,8,12 -> out_valid=1 after first edge; out_pc sequence 0,4,8,12, one per cycle; retire_cnt=4 after four pops.
REQ-032 out_ready=0 for 5 cycles after reset -> count saturates at 2, im_addr holds 8, out_pc stays 0; raising out_ready drains pc 0,4 then 8.
REQ-033 redirect=1, redirect_pc=0x40 while count=2 and out_ready=1 -> retire_cnt+1; next cycle out_valid=0; following cycle out_pc=0x40.
REQ-034 Sequential fetch to 124 then 128 with IM_SIZE=128 -> entry pc=124 delivered; fault=1 the cycle after im_addr=128; no pc=128 entry.
REQ-035 redirect_pc=0x06 (misaligned) -> fault=1 next cycle, out_valid=0 persists; subsequent redirect_pc=0x00 -> fault=0 and pc 0 delivered.
REQ-036 rst_n pulsed low asynchronously between edges with count=2 -> out_valid=0 and fault=0 immediately; restart fetch at RESET_PC.
